// File: rtl/mem_stage_wb_master.sv
// mem_stage_wb_master
//   Data-memory Wishbone master for the MEM pipeline stage. Takes one
//   load/store from the EX/MEM register and runs one classic single
//   read/write cycle for it. It holds the finished result until EX/MEM
//   advances, so a held entry never causes a second access.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no access in flight; starts a cycle when an aligned request is
//         | present
//   BUSY  | cyc/stb asserted, waiting for wb_ack_i
//   DONE  | access finished, result held until stage_advance
//
// Ports
//   clk, reset            clock, async active-high reset
//   req_*                 request from EX/MEM (valid, we, funct3, addr, wdata)
//   stage_advance         EX/MEM loads a new entry this edge
//   busy                  stall request to the stall/flush controller
//   misaligned            current request is misaligned (no bus cycle)
//   rdata, rdata_valid    extended load result, valid in DONE
//   wb_*                  Wishbone classic master interface
module mem_stage_wb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic                    stage_advance,
  output logic                    busy,
  output logic                    misaligned,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_valid,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
);

  localparam int SEL_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic                  is_byte;
  logic                  is_half;
  logic                  misal_raw;
  logic                  start;
  logic [SEL_W-1:0]      sel_next;
  logic [DATA_WIDTH-1:0] dat_next;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  // Any funct3 that is not a byte or halfword code behaves as a word access.
  always_comb begin
    is_byte = (req_funct3 == 3'b000) || (req_funct3 == 3'b100);
    is_half = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
  end

  always_comb begin
    misal_raw = 1'b0;
    if (is_half)
      misal_raw = req_addr[0];
    else if (!is_byte)
      misal_raw = (req_addr[1:0] != 2'b00);
  end

  assign misaligned = !reset && req_valid && misal_raw;
  assign start      = req_valid && !misal_raw;
  assign busy       = !reset && (((state == IDLE) && start) || (state == BUSY));

  // Lane select and store data are replicated across lanes, so the slave
  // only has to honour sel.
  always_comb begin
    sel_next = '1;
    dat_next = req_wdata;
    if (is_byte) begin
      sel_next = SEL_W'(1) << req_addr[1:0];
      dat_next = {4{req_wdata[7:0]}};
    end else if (is_half) begin
      sel_next = SEL_W'(3) << req_addr[1:0];
      dat_next = {2{req_wdata[15:0]}};
    end
  end

  // Load extraction uses the latched byte offset, because wb_adr_o is
  // word aligned.
  always_comb begin
    shifted = wb_dat_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},         shifted[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}},        shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          rdata_valid <= 1'b0;
          if (start) begin
            we_q     <= req_we;
            f3_q     <= req_funct3;
            off_q    <= req_addr[1:0];
            wb_adr_o <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            wb_dat_o <= dat_next;
            wb_sel_o <= sel_next;
            wb_we_o  <= req_we;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (wb_ack_i) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            rdata_valid <= !we_q;
            if (!we_q)
              rdata <= load_ext;
            state <= DONE;
          end
        end
        DONE: begin
          // Stay here while EX/MEM is stalled, even with req_valid still
          // high, so the same entry is never serviced twice.
          if (stage_advance) begin
            rdata_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_wb_master.sv
// Testbench for mem_stage_wb_master: directed cases plus random load/store
// traffic, with a scoreboard of expected bus transactions and results.
module tb_mem_stage_wb_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stage_advance;
  logic        busy;
  logic        misaligned;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i = 1'b0;

  mem_stage_wb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stage_advance(stage_advance),
    .busy(busy), .misaligned(misaligned), .rdata(rdata), .rdata_valid(rdata_valid),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_hs = 0;
  int   n_pushed = 0;
  int   cur_waits = 0;
  int   wcnt = 0;
  bit   ack_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the access rules: size from funct3,
  // lanes from the byte offset, plain arithmetic for extension.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rd, output exp_t e, output bit mis);
    int nbytes;
    int o;
    logic [31:0] sh;
    o = int'(addr[1:0]);
    case (f3)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      default:    nbytes = 4;
    endcase
    mis = (o % nbytes) != 0;
    e.we  = we;
    e.adr = addr & 32'hFFFF_FFFC;
    e.sel = 4'(((1 << nbytes) - 1) << o);
    if (nbytes == 1)      e.dat = (wdata & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) e.dat = (wdata & 32'hFFFF) * 32'h0001_0001;
    else                  e.dat = wdata;
    sh = rd >> (8 * o);
    case (f3)
      3'd0: e.rdata = ((sh & 32'hFF) >= 32'h80) ? ((sh & 32'hFF) | 32'hFFFF_FF00) : (sh & 32'hFF);
      3'd4: e.rdata = sh & 32'hFF;
      3'd1: e.rdata = ((sh & 32'hFFFF) >= 32'h8000) ? ((sh & 32'hFFFF) | 32'hFFFF_0000) : (sh & 32'hFFFF);
      3'd5: e.rdata = sh & 32'hFFFF;
      default: e.rdata = rd;
    endcase
  endfunction

  // Slave: acks after cur_waits wait states; ack_hold keeps ack high when
  // no cycle is active.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      wcnt = 0;
      wb_ack_i = 1'b0;
    end else if (wb_cyc_o && wb_stb_o) begin
      wb_ack_i = (wcnt >= cur_waits);
      wcnt++;
    end else begin
      wcnt = 0;
      wb_ack_i = ack_hold;
    end
  end

  // Monitor: every handshake pops one expected transaction; the next
  // cycle (DONE) is checked for the result.
  bit   pend = 0;
  exp_t pe;
  always @(negedge clk) begin
    if (pend) begin
      pend = 0;
      chk("done_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rdata_valid", 32'(rdata_valid), 32'(!pe.we));
      if (!pe.we) chk("rdata", rdata, pe.rdata);
    end
    if (!reset && wb_cyc_o && wb_stb_o && wb_ack_i) begin
      n_hs++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_bus_cycle actual=adr %h required=no cycle", wb_adr_o);
      end else begin
        pe = q.pop_front();
        chk("wb_adr", wb_adr_o, pe.adr);
        chk("wb_sel", 32'(wb_sel_o), 32'(pe.sel));
        chk("wb_we", 32'(wb_we_o), 32'(pe.we));
        chk("wb_dat_o", wb_dat_o, pe.dat);
        pend = 1;
      end
    end
  end

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd,
                        input int waits, input int hold);
    exp_t e;
    bit   mis;
    int   cnt;
    int   guard;
    model(we, f3, addr, wdata, rd, e, mis);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; wb_dat_i = rd; stage_advance = 1'b0; cur_waits = waits;
    #1;
    chk("misaligned", 32'(misaligned), 32'(mis));
    if (mis) begin
      chk("mis_busy", 32'(busy), 32'd0);
      repeat (3) begin
        @(negedge clk); #1;
        chk("mis_no_cyc", 32'(wb_cyc_o), 32'd0);
      end
      return;
    end
    q.push_back(e);
    n_pushed++;
    cnt = 0;
    guard = 0;
    while (busy && guard < 40) begin
      cnt++;
      guard++;
      @(negedge clk); #1;
    end
    chk("busy_cycles", 32'(cnt), 32'(2 + waits));
    for (int i = 0; i < hold; i++) begin
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_cyc", 32'(wb_cyc_o), 32'd0);
      if (!we) chk("hold_rdata", rdata, e.rdata);
      @(negedge clk); #1;
    end
    stage_advance = 1'b1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0;
    stage_advance = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3s [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    int hs0;
    reset = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0004;
    req_wdata = '0; stage_advance = 1'b0; wb_dat_i = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    req_addr = 32'h0000_0001;
    #1;
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed cases.
    do_txn(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0);
    do_txn(1'b0, 3'd0, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, 0, 0);
    do_txn(1'b0, 3'd4, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, 0, 0);
    do_txn(1'b1, 3'd1, 32'h2000_0002, 32'h0000_1234, 32'h0, 3, 0);
    ack_hold = 1;
    hs0 = n_hs;
    do_txn(1'b0, 3'd5, 32'h3000_0002, 32'h0, 32'hA5F0_1234, 0, 4);
    go_idle();
    ack_hold = 0;
    chk("single_stb", 32'(n_hs - hs0), 32'd1);
    do_txn(1'b0, 3'd2, 32'h4000_0001, 32'h0, 32'h0, 0, 0);
    go_idle();

    // Reset while BUSY: cyc/stb fall without a clock edge, no retry.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h5000_0000;
    cur_waits = 20;
    @(posedge clk); #1;
    chk("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_cyc", 32'(wb_cyc_o), 32'd0);
    end
    do_txn(1'b0, 3'd2, 32'h6000_0008, 32'h0, 32'h1234_5678, 0, 0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      do_txn(1'($urandom_range(1)), f3s[$urandom_range(6)], a, $urandom, $urandom,
             $urandom_range(3), $urandom_range(3));
    end
    go_idle();
    repeat (4) @(negedge clk);
    #1;
    chk("handshakes", 32'(n_hs), 32'(n_pushed));
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
